// File: rtl/mem_bridge_pkg.sv
// Shared LC-3b bus types plus the bridge state encoding and the timeout read-back word.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    MB_IDLE = 2'd0,
    MB_BUSY = 2'd1,
    MB_DONE = 2'd2
  } mem_bridge_state;

  localparam lc3b_word MEM_ERR_DATA = 16'hDEAD;

  // Physical memory is word addressed; the byte-select bit is carried by the lane mask.
  function automatic lc3b_word word_align(input lc3b_word addr);
    return {addr[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/mem_bridge_if.sv
// Upstream (control/MAR/MDR) and physical-memory signals of the bridge.
// mem_error exists only when MEM_TIMEOUT_EN is defined.
interface mem_bridge_if;
  import lc3b_types::*;

  logic          mem_read;
  logic          mem_write;
  lc3b_mem_wmask mem_byte_enable;
  lc3b_word      mem_address;
  lc3b_word      mem_wdata;
  logic          mem_resp;
  lc3b_word      mem_rdata;

  logic          pmem_read;
  logic          pmem_write;
  lc3b_word      pmem_address;
  lc3b_word      pmem_wdata;
  lc3b_mem_wmask pmem_byte_enable;
  logic          pmem_resp;
  lc3b_word      pmem_rdata;

`ifdef MEM_TIMEOUT_EN
  logic          mem_error;

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_resp, mem_rdata, mem_error,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable,
    output pmem_resp, pmem_rdata
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_resp, mem_rdata, mem_error,
    output pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable,
    input  pmem_resp, pmem_rdata
  );
`else
  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_resp, mem_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable,
    output pmem_resp, pmem_rdata
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_resp, mem_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable,
    input  pmem_resp, pmem_rdata
  );
`endif

endinterface

// File: rtl/mem_bridge_watchdog.sv
// mem_watchdog: counts consecutive BUSY cycles and flags the last one before abort.
// Instantiated by mem_bridge only when MEM_TIMEOUT_EN is defined.
module mem_watchdog #(
  parameter logic [7:0] LIMIT = 8'd255
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expired
);

  logic [7:0] count;

  // Leaving BUSY clears the count, so every new BUSY entry starts from zero.
  always_ff @(posedge clk) begin
    if (rst || !run) count <= 8'd0;
    else             count <= count + 8'd1;
  end

  assign expired = run && (count == LIMIT - 8'd1);

endmodule

// File: rtl/mem_bridge.sv
// mem_bridge: single-outstanding IDLE/BUSY/DONE bridge from LC-3b control to physical memory.
// Define MEM_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES and raise a sticky mem_error.
module mem_bridge
  import lc3b_types::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic         clk,
  input logic         rst,
  mem_bridge_if.slave bus
);

  localparam logic [1:0] IDLE = MB_IDLE;
  localparam logic [1:0] BUSY = MB_BUSY;
  localparam logic [1:0] DONE = MB_DONE;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_bridge: TIMEOUT_CYCLES must be within 1..255");
  end

  logic [1:0]    state;
  lc3b_word      addr_q;
  lc3b_word      wdata_q;
  lc3b_word      rdata_q;
  lc3b_mem_wmask mask_q;
  logic          write_q;
  logic          expired;

`ifdef MEM_TIMEOUT_EN
  logic error_q;

  mem_watchdog #(
    .LIMIT (8'(TIMEOUT_CYCLES))
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .run     (state == BUSY),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst)                                       error_q <= 1'b0;
    else if (state == BUSY && !bus.pmem_resp && expired) error_q <= 1'b1;
  end

  assign bus.mem_error = error_q;
`else
  assign expired = 1'b0;
`endif

  // NOTE: all state and latched fields use non-blocking assignments so every
  // branch sees the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mask_q  <= '0;
      write_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.mem_read || bus.mem_write) begin
            addr_q  <= word_align(bus.mem_address);
            wdata_q <= bus.mem_wdata;
            mask_q  <= bus.mem_byte_enable;
            write_q <= bus.mem_write;
            // A write with no lanes enabled has nothing to do in memory.
            state   <= (bus.mem_write && bus.mem_byte_enable == 2'b00) ? DONE : BUSY;
          end
        end
        BUSY: begin
          if (bus.pmem_resp) begin
            if (!write_q) rdata_q <= bus.pmem_rdata;
            state <= DONE;
          end else if (expired) begin
            rdata_q <= MEM_ERR_DATA;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pmem_read        = (state == BUSY) && !write_q;
  assign bus.pmem_write       = (state == BUSY) &&  write_q;
  assign bus.pmem_address     = addr_q;
  assign bus.pmem_wdata       = wdata_q;
  assign bus.pmem_byte_enable = mask_q;
  assign bus.mem_resp         = (state == DONE);
  assign bus.mem_rdata        = rdata_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Scoreboard bench for mem_bridge: directed requests push expected pmem accesses and
// responses; a negedge monitor pops and compares. Timeout cases run with MEM_TIMEOUT_EN.
module tb_mem_bridge;
  import lc3b_types::*;

  typedef struct {
    lc3b_word rdata;
    int       cyc;
  } resp_t;

  typedef struct {
    logic          wr;
    lc3b_word      addr;
    lc3b_word      wdata;
    lc3b_mem_wmask mask;
    int            len;
  } pmem_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  resp_t resp_q[$];
  pmem_t pmem_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_bridge_if bus();

`ifdef MEM_TIMEOUT_EN
  mem_bridge #(.TIMEOUT_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  mem_bridge dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  pmem_t cur;
  logic  active = 1'b0;
  logic  bogus  = 1'b0;
  int    len    = 0;
  resp_t e;

  always @(negedge clk) begin
    if (bus.mem_resp) begin
      if (resp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_mem_resp: got resp at cycle %0d expected none", cyc);
      end else begin
        e = resp_q.pop_front();
        check("mem_rdata", bus.mem_rdata, e.rdata);
        check("mem_resp_cycle", cyc, e.cyc);
      end
    end

    if (bus.pmem_read || bus.pmem_write) begin
      if (!active) begin
        active = 1'b1;
        len    = 0;
        bogus  = (pmem_q.size() == 0);
        if (bogus) begin
          checks++; errors++;
          $display("FAIL unexpected_pmem_access: got strobe at cycle %0d expected none", cyc);
        end else begin
          cur = pmem_q.pop_front();
        end
      end
      len++;
      if (!bogus) begin
        check("pmem_read",        bus.pmem_read,        !cur.wr);
        check("pmem_write",       bus.pmem_write,       cur.wr);
        check("pmem_address",     bus.pmem_address,     cur.addr);
        check("pmem_wdata",       bus.pmem_wdata,       cur.wdata);
        check("pmem_byte_enable", bus.pmem_byte_enable, cur.mask);
      end
    end else if (active) begin
      if (!bogus) check("pmem_strobe_len", len, cur.len);
      active = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input lc3b_word addr,
                       input lc3b_word wdata, input lc3b_mem_wmask mask, output int n);
    bus.mem_read        = rd;
    bus.mem_write       = wr;
    bus.mem_address     = addr;
    bus.mem_wdata       = wdata;
    bus.mem_byte_enable = mask;
    n = cyc;
  endtask

  // Answers the pending pmem access in its d-th strobe cycle.
  task automatic pmem_respond(input int d, input lc3b_word data, input bit disturb);
    int k = 0;
    tick();
    while (!(bus.pmem_read || bus.pmem_write) && k < 20) begin
      tick();
      k++;
    end
    if (k >= 20) begin
      checks++; errors++;
      $display("FAIL pmem_strobe_wait: got no strobe expected one within 20 cycles");
      return;
    end
    if (disturb) begin
      bus.mem_address     = 16'hFFFF;
      bus.mem_wdata       = 16'h0000;
      bus.mem_byte_enable = 2'b01;
    end
    repeat (d - 1) tick();
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = data;
    tick();
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = 16'h0000;
  endtask

  task automatic finish_req();
    int k = 0;
    while (!bus.mem_resp && k < 50) begin
      tick();
      k++;
    end
    if (k >= 50) begin
      checks++; errors++;
      $display("FAIL mem_resp_wait: got no mem_resp expected one within 50 cycles");
    end
    tick();
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    int n;
    rst = 1'b1;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_byte_enable = 2'b00;
    bus.mem_address = 16'h0000; bus.mem_wdata = 16'h0000;
    bus.pmem_resp = 1'b0; bus.pmem_rdata = 16'h0000;
    repeat (2) tick();

    check("rst_mem_resp",         bus.mem_resp,         0);
    check("rst_pmem_read",        bus.pmem_read,        0);
    check("rst_pmem_write",       bus.pmem_write,       0);
    check("rst_mem_rdata",        bus.mem_rdata,        16'h0000);
    check("rst_pmem_address",     bus.pmem_address,     16'h0000);
    check("rst_pmem_wdata",       bus.pmem_wdata,       16'h0000);
    check("rst_pmem_byte_enable", bus.pmem_byte_enable, 2'b00);
`ifdef MEM_TIMEOUT_EN
    check("rst_mem_error",        bus.mem_error,        0);
`endif
    rst = 1'b0;
    tick();

    // Read, odd byte address, answered in the 3rd strobe cycle; upstream wiggles during BUSY.
    issue(1'b1, 1'b0, 16'h0101, 16'h5555, 2'b11, n);
    pmem_q.push_back('{wr: 1'b0, addr: 16'h0100, wdata: 16'h5555, mask: 2'b11, len: 3});
    resp_q.push_back('{rdata: 16'h1234, cyc: n + 4});
    pmem_respond(3, 16'h1234, 1'b1);
    finish_req();

    // Write, high lane only, answered immediately: mem_rdata keeps the last read.
    issue(1'b0, 1'b1, 16'h0040, 16'hBEEF, 2'b10, n);
    pmem_q.push_back('{wr: 1'b1, addr: 16'h0040, wdata: 16'hBEEF, mask: 2'b10, len: 1});
    resp_q.push_back('{rdata: 16'h1234, cyc: n + 2});
    pmem_respond(1, 16'h0000, 1'b0);
    finish_req();

    // Write with empty mask completes without touching physical memory.
    issue(1'b0, 1'b1, 16'h0011, 16'h1111, 2'b00, n);
    resp_q.push_back('{rdata: 16'h1234, cyc: n + 1});
    finish_req();

    // Read and write together: the write wins and returned pmem_rdata is ignored.
    issue(1'b1, 1'b1, 16'h0203, 16'hCAFE, 2'b01, n);
    pmem_q.push_back('{wr: 1'b1, addr: 16'h0202, wdata: 16'hCAFE, mask: 2'b01, len: 2});
    resp_q.push_back('{rdata: 16'h1234, cyc: n + 3});
    pmem_respond(2, 16'h9999, 1'b0);
    finish_req();

    // Stray pmem_resp in IDLE, then a minimum-latency read.
    bus.pmem_resp = 1'b1; bus.pmem_rdata = 16'h7777;
    tick();
    bus.pmem_resp = 1'b0; bus.pmem_rdata = 16'h0000;
    tick();
    issue(1'b1, 1'b0, 16'h1000, 16'h0000, 2'b11, n);
    pmem_q.push_back('{wr: 1'b0, addr: 16'h1000, wdata: 16'h0000, mask: 2'b11, len: 1});
    resp_q.push_back('{rdata: 16'hA5A5, cyc: n + 2});
    pmem_respond(1, 16'hA5A5, 1'b0);
    finish_req();

    // Reset while BUSY aborts without a response; the next read still works.
    issue(1'b1, 1'b0, 16'h2222, 16'h0000, 2'b11, n);
    pmem_q.push_back('{wr: 1'b0, addr: 16'h2222, wdata: 16'h0000, mask: 2'b11, len: 1});
    tick();
    rst = 1'b1;
    bus.mem_read = 1'b0;
    tick();
    check("abort_pmem_read", bus.pmem_read, 0);
    check("abort_mem_resp",  bus.mem_resp,  0);
    check("abort_mem_rdata", bus.mem_rdata, 16'h0000);
    rst = 1'b0;
    tick();
    issue(1'b1, 1'b0, 16'h3334, 16'h0000, 2'b11, n);
    pmem_q.push_back('{wr: 1'b0, addr: 16'h3334, wdata: 16'h0000, mask: 2'b11, len: 2});
    resp_q.push_back('{rdata: 16'h0F0F, cyc: n + 3});
    pmem_respond(2, 16'h0F0F, 1'b0);
    finish_req();

`ifdef MEM_TIMEOUT_EN
    // No pmem_resp: abort after 4 BUSY cycles with the error word, error stays sticky.
    issue(1'b1, 1'b0, 16'h4444, 16'h0000, 2'b11, n);
    pmem_q.push_back('{wr: 1'b0, addr: 16'h4444, wdata: 16'h0000, mask: 2'b11, len: 4});
    resp_q.push_back('{rdata: 16'hDEAD, cyc: n + 5});
    finish_req();
    check("timeout_mem_error", bus.mem_error, 1);
    issue(1'b1, 1'b0, 16'h4446, 16'h0000, 2'b11, n);
    pmem_q.push_back('{wr: 1'b0, addr: 16'h4446, wdata: 16'h0000, mask: 2'b11, len: 1});
    resp_q.push_back('{rdata: 16'h1357, cyc: n + 2});
    pmem_respond(1, 16'h1357, 1'b0);
    finish_req();
    check("sticky_mem_error", bus.mem_error, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_clears_mem_error", bus.mem_error, 0);
    tick();
`endif

    repeat (3) tick();
    check("resp_queue_drained", resp_q.size(), 0);
    check("pmem_queue_drained", pmem_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, number of BUSY cycles before abort (only used with MEM_TIMEOUT_EN); legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 mem_read  input  1  upstream read request, held by control until mem_resp.
REQ-005 mem_write  input  1  upstream write request, held until mem_resp.
REQ-006 mem_byte_enable  input  2  lc3b_mem_wmask, write lane mask [1]=high byte, [0]=low byte.
REQ-007 mem_address  input  16  lc3b_word byte address from MAR.
REQ-008 mem_wdata  input  16  lc3b_word write data from MDR.
REQ-009 mem_resp  output  1  one-cycle completion pulse to control.
REQ-010 mem_rdata  output  16  read data, valid in the mem_resp cycle.
REQ-011 pmem_read / pmem_write  output  1 each  physical memory request strobes.
REQ-012 pmem_address  output  16  latched address with bit 0 forced to 0.
REQ-013 pmem_wdata  output  16; pmem_byte_enable  output  2  latched write data and mask.
REQ-014 pmem_resp  input  1; pmem_rdata  input  16  physical completion and read data.
REQ-015 mem_error  output  1  sticky timeout flag (present only with MEM_TIMEOUT_EN).

Function
REQ-016 FSM states IDLE, BUSY, DONE; every output is a registered function of state and latched fields.
REQ-017 IDLE: on sampling mem_read or mem_write, latch address, wdata, mask and op, and go to BUSY.
REQ-018 Both mem_read and mem_write high: write wins; read is ignored.
REQ-019 Write with mem_byte_enable=2'b00: IDLE -> DONE directly, no pmem access, mem_resp on the next cycle.
REQ-020 BUSY: hold pmem_read or pmem_write and all pmem fields constant until pmem_resp is sampled high.
REQ-021 On pmem_resp in BUSY, capture pmem_rdata (reads only) and go to DONE.
REQ-022 DONE: mem_resp=1 for exactly one cycle, pmem strobes low, mem_rdata = captured data; next state IDLE.
REQ-023 Latency: request sampled at cycle N -> pmem strobe from N+1.
REQ-024 pmem_resp sampled at cycle M -> mem_resp at M+1; minimum round trip is mem_resp at N+2.
REQ-025 mem_rdata holds its last value outside DONE; writes leave mem_rdata unchanged.
REQ-026 Upstream changes to the inputs during BUSY/DONE have no effect; the latched fields are used.
REQ-027 pmem_resp while in IDLE or DONE is ignored.

Reset
REQ-028 rst: state IDLE, mem_resp=0, pmem_read=0, pmem_write=0, mem_rdata=0, pmem_address/wdata=0, pmem_byte_enable=0, mem_error=0.
REQ-029 rst asserted in BUSY or DONE: abort; no mem_resp is issued for the aborted request.

Configuration
REQ-030 Macro MEM_TIMEOUT_EN defined: an 8-bit counter clears on BUSY entry and increments each BUSY cycle.
REQ-031 With MEM_TIMEOUT_EN, reaching TIMEOUT_CYCLES without pmem_resp drops the strobes and goes to DONE with mem_rdata=16'hDEAD.
REQ-032 With MEM_TIMEOUT_EN, a timeout sets mem_error, which stays set until rst.
REQ-033 Macro undefined: BUSY waits indefinitely, and neither the counter nor mem_error exists.

Structure
REQ-034 lc3b_types holds lc3b_word and lc3b_mem_wmask (existing) plus a new mem_bridge_state enum and the constant MEM_ERR_DATA=16'hDEAD.
REQ-035 A sub-module mem_watchdog (counter plus expiry flag) is natural and is instantiated only under MEM_TIMEOUT_EN.

Verification
REQ-036 Read: addr 16'h0101, pmem_resp after 3 cycles with rdata 16'h1234 -> pmem_address 16'h0100, one mem_resp pulse, mem_rdata 16'h1234.
REQ-037 Write: addr 16'h0040, data 16'hBEEF, mask 2'b10, pmem_resp next cycle -> pmem_write held 1 cycle with mask 2'b10; mem_resp at N+2.
REQ-038 Write with mask 2'b00 -> no pmem strobe; mem_resp at N+1.
REQ-039 Read and write both high -> only pmem_write asserted.
REQ-040 rst in BUSY -> strobes low the next cycle, no mem_resp; a new read then completes normally.
REQ-041 MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4, no pmem_resp -> abort after 4 BUSY cycles; mem_resp with 16'hDEAD; mem_error=1 until rst.
